// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Brings a set of downstream reset domains out of reset one at a time. It
// waits for the PLL/MMCM to report a stable lock, then releases rst_out[0],
// rst_out[1], ... with DELAY_CYCLES clocks between releases. Lock loss or a
// soft restart request at any point after the hold phase puts every domain
// back into reset and runs the whole sequence again.
//
// Parameters
//   NUM_RST      number of sequenced reset outputs (2..16)
//   DELAY_CYCLES hold time in ASSERT and spacing between releases (2..65535)
//   LOCK_FILTER  consecutive locked cycles required before releasing (1..255)
//
// Ports
//   clk           single rising-edge clock
//   async_reset_n asynchronous active-low reset; release is synchronized
//                 internally through a 3-stage synchronizer
//   pll_locked    PLL/MMCM lock indication, asynchronous to clk
//   soft_rst_req  single-cycle synchronous request to re-run the sequence
//   rst_out       active-high resets, bit 0 released first (registered)
//   seq_done      high once every rst_out bit is released (registered)
//   seq_state     ASSERT=0, LOCK_WAIT=1, RELEASE=2, DONE=3 (registered)
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_RST      = 4,
  parameter int DELAY_CYCLES = 16,
  parameter int LOCK_FILTER  = 8
) (
  input  logic               clk,
  input  logic               async_reset_n,
  input  logic               pll_locked,
  input  logic               soft_rst_req,
  output logic [NUM_RST-1:0] rst_out,
  output logic               seq_done,
  output logic [1:0]         seq_state
);

  // The hold and delay counters run 0..DELAY_CYCLES-1; the terminal compare
  // happens on the value held during the last counted cycle, so the step to
  // DELAY_CYCLES and the wrap to 0 land on the same edge.
  localparam int DLY_W  = $clog2(DELAY_CYCLES);
  // The filter counter runs 0..LOCK_FILTER-1 for the same reason.
  localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int IDX_W  = $clog2(NUM_RST);

  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DELAY_CYCLES - 32'sd1);
  localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(32'sd1);
  localparam logic [DLY_W-1:0]  DLY_ZERO  = DLY_W'(32'sd0);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 32'sd1);
  localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(32'sd1);
  localparam logic [FILT_W-1:0] FILT_ZERO = FILT_W'(32'sd0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RST - 32'sd1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(32'sd1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(32'sd0);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_LOCK_WAIT = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  logic [2:0]                      rst_sync_r;
  (* ASYNC_REG = "TRUE" *) logic [1:0] lock_sync_r;

  state_e                          state_r;
  logic [DLY_W-1:0]                hold_cnt_r;
  logic [FILT_W-1:0]               filt_cnt_r;
  logic [DLY_W-1:0]                dly_cnt_r;
  logic [IDX_W-1:0]                idx_r;
  logic [NUM_RST-1:0]              rst_out_r;
  logic                            seq_done_r;

  logic                            run_s;
  logic                            locked_s;
  logic                            restart_s;

  // Reset bridge: asserts with async_reset_n, releases three clocks later.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rst_sync_r <= 3'b000;
    end else begin
      rst_sync_r <= {rst_sync_r[1:0], 1'b1};
    end
  end

  // Two-flop synchronizer bringing the asynchronous lock flag into clk.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], pll_locked};
    end
  end

  assign run_s     = rst_sync_r[2];
  assign locked_s  = lock_sync_r[1];
  // Lock loss and a soft request have the identical effect, so a coincident
  // pair collapses into one restart.
  assign restart_s = soft_rst_req | ~locked_s;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_r    <= ST_ASSERT;
      hold_cnt_r <= DLY_ZERO;
      filt_cnt_r <= FILT_ZERO;
      dly_cnt_r  <= DLY_ZERO;
      idx_r      <= IDX_ZERO;
      rst_out_r  <= {NUM_RST{1'b1}};
      seq_done_r <= 1'b0;
    end else if (!run_s) begin
      // Still inside the reset bridge: hold the reset values.
      state_r    <= ST_ASSERT;
      hold_cnt_r <= DLY_ZERO;
      filt_cnt_r <= FILT_ZERO;
      dly_cnt_r  <= DLY_ZERO;
      idx_r      <= IDX_ZERO;
      rst_out_r  <= {NUM_RST{1'b1}};
      seq_done_r <= 1'b0;
    end else if ((state_r != ST_ASSERT) && restart_s) begin
      // Common ASSERT entry from any later state.
      state_r    <= ST_ASSERT;
      hold_cnt_r <= DLY_ZERO;
      filt_cnt_r <= FILT_ZERO;
      dly_cnt_r  <= DLY_ZERO;
      idx_r      <= IDX_ZERO;
      rst_out_r  <= {NUM_RST{1'b1}};
      seq_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          // Lock state is ignored here; only the hold time matters.
          rst_out_r  <= {NUM_RST{1'b1}};
          seq_done_r <= 1'b0;
          if (soft_rst_req) begin
            hold_cnt_r <= DLY_ZERO;
          end else if (hold_cnt_r == DLY_LAST) begin
            hold_cnt_r <= DLY_ZERO;
            filt_cnt_r <= FILT_ZERO;
            state_r    <= ST_LOCK_WAIT;
          end else begin
            hold_cnt_r <= hold_cnt_r + DLY_ONE;
          end
        end

        ST_LOCK_WAIT: begin
          // Reaching here means locked_s=1 this cycle (a 0 restarts above).
          if (filt_cnt_r == FILT_LAST) begin
            filt_cnt_r <= FILT_ZERO;
            dly_cnt_r  <= DLY_ZERO;
            idx_r      <= IDX_ZERO;
            state_r    <= ST_RELEASE;
          end else begin
            filt_cnt_r <= filt_cnt_r + FILT_ONE;
          end
        end

        ST_RELEASE: begin
          if (dly_cnt_r == DLY_LAST) begin
            dly_cnt_r        <= DLY_ZERO;
            rst_out_r[idx_r] <= 1'b0;
            if (idx_r == IDX_LAST) begin
              state_r    <= ST_DONE;
              seq_done_r <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            dly_cnt_r <= dly_cnt_r + DLY_ONE;
          end
        end

        ST_DONE: begin
          rst_out_r  <= {NUM_RST{1'b0}};
          seq_done_r <= 1'b1;
        end

        default: begin
          // Unreachable encoding: fall back to the safe, all-reset state.
          state_r    <= ST_ASSERT;
          hold_cnt_r <= DLY_ZERO;
          filt_cnt_r <= FILT_ZERO;
          dly_cnt_r  <= DLY_ZERO;
          idx_r      <= IDX_ZERO;
          rst_out_r  <= {NUM_RST{1'b1}};
          seq_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out   = rst_out_r;
  assign seq_done  = seq_done_r;
  assign seq_state = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed scenarios plus a randomized lock/soft-request phase for
// reset_sequencer at default parameters. Expected outputs come from a
// timeline model: elapsed cycles in the hold phase, length of the current
// locked run, and elapsed cycles since release began (released bits =
// elapsed / DELAY_CYCLES).
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int LF = 8;

  logic         clk;
  logic         async_reset_n;
  logic         pll_locked;
  logic         soft_rst_req;
  logic [N-1:0] rst_out;
  logic         seq_done;
  logic [1:0]   seq_state;

  int tests_run;
  int tests_failed;
  int cyc;

  reset_sequencer #(
    .NUM_RST      (N),
    .DELAY_CYCLES (D),
    .LOCK_FILTER  (LF)
  ) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .pll_locked    (pll_locked),
    .soft_rst_req  (soft_rst_req),
    .rst_out       (rst_out),
    .seq_done      (seq_done),
    .seq_state     (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit           m_s1, m_s2;     // lock synchronizer pipeline
  int           m_rs;           // clocks seen since reset release (sat 3)
  int           m_since;        // hold-phase cycles since last restart
  int           m_lockrun;      // consecutive locked cycles after hold
  bit           m_released;     // release phase started
  int           m_rel;          // cycles since release phase started
  logic [N-1:0] exp_rst;
  logic         exp_done;
  logic [1:0]   exp_state;

  function automatic void model_restart();
    m_since    = 0;
    m_lockrun  = 0;
    m_released = 1'b0;
    m_rel      = 0;
  endfunction

  function automatic void model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_rs = 0;
    model_restart();
  endfunction

  function automatic void model_edge(input bit pll, input bit srq);
    bit ls;
    bit act;
    if (!async_reset_n) begin
      model_reset();
      return;
    end
    ls   = m_s2;
    act  = (m_rs >= 3);
    m_s2 = m_s1;
    m_s1 = pll;
    if (m_rs < 3) m_rs++;
    if (!act) return;
    if (m_since < D) begin
      if (srq) m_since = 0;
      else     m_since++;
    end else if (!ls || srq) begin
      model_restart();
    end else if (m_released) begin
      if (m_rel < N * D) m_rel++;
    end else begin
      m_lockrun++;
      if (m_lockrun == LF) begin
        m_released = 1'b1;
        m_rel      = 0;
      end
    end
  endfunction

  function automatic void model_expect();
    int n;
    exp_rst = '1;
    if (m_since < D) begin
      exp_done  = 1'b0;
      exp_state = 2'd0;
    end else if (!m_released) begin
      exp_done  = 1'b0;
      exp_state = 2'd1;
    end else begin
      n = m_rel / D;
      if (n > N) n = N;
      for (int b = 0; b < n; b++) exp_rst[b] = 1'b0;
      exp_done  = (n == N);
      exp_state = exp_done ? 2'd3 : 2'd2;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_model();
    model_expect();
    check("rst_out", {28'd0, rst_out}, {28'd0, exp_rst});
    check("seq_done", {31'd0, seq_done}, {31'd0, exp_done});
    check("seq_state", {30'd0, seq_state}, {30'd0, exp_state});
  endtask

  task automatic step(input bit pll, input bit srq);
    pll_locked   = pll;
    soft_rst_req = srq;
    @(posedge clk);
    cyc++;
    model_edge(pll, srq);
    #1;
    check_model();
  endtask

  // Runs with lock held and checks release latency, spacing and seq_done.
  task automatic run_release(input string tag, input int exp_first);
    int fall [N];
    int done_e;
    int start;
    start  = cyc;
    done_e = -1;
    for (int b = 0; b < N; b++) fall[b] = -1;
    for (int k = 0; k < 120; k++) begin
      step(1'b1, 1'b0);
      for (int b = 0; b < N; b++)
        if (fall[b] < 0 && rst_out[b] === 1'b0) fall[b] = cyc;
      if (done_e < 0 && seq_done === 1'b1) done_e = cyc;
    end
    check({tag, "_first"}, fall[0] - start, exp_first);
    for (int b = 1; b < N; b++)
      check({tag, "_spacing"}, fall[b] - fall[b-1], D);
    check({tag, "_done_edge"}, done_e, fall[N-1]);
  endtask

  task automatic wait_for_1100(input string tag);
    int guard;
    guard = 0;
    while (rst_out !== 4'b1100 && guard < 200) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check({tag, "_reached"}, guard < 200, 1);
  endtask

  initial begin
    int bad;
    int hold;
    tests_run     = 0;
    tests_failed  = 0;
    cyc           = 0;
    async_reset_n = 1'b0;
    pll_locked    = 1'b1;
    soft_rst_req  = 1'b0;
    model_reset();

    // Reset state.
    #12;
    check("reset_rst_out", {28'd0, rst_out}, 32'h0000000F);
    check("reset_seq_done", {31'd0, seq_done}, 32'd0);
    check("reset_seq_state", {30'd0, seq_state}, 32'd0);
    check_model();

    // Full sequence from reset release: bridge 3 + hold + filter + delay.
    @(posedge clk);
    #1;
    async_reset_n = 1'b1;
    run_release("por", 3 + D + LF + D);

    // Soft request in DONE: all reset next cycle, identical sequence again.
    step(1'b1, 1'b1);
    check("soft_all_asserted", {28'd0, rst_out}, 32'h0000000F);
    check("soft_done_low", {31'd0, seq_done}, 32'd0);
    run_release("soft", D + LF + D);

    // Lock glitch every 5 cycles keeps the filter from ever completing.
    step(1'b1, 1'b1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step((k % 5) != 4, 1'b0);
      if (rst_out !== 4'b1111 || seq_state === 2'd2) bad++;
    end
    check("glitch_never_release", bad, 0);

    // Lock loss after bit 1 released: all reset within 3 cycles, then rerun.
    wait_for_1100("lockloss");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("lockloss_rst_out", {28'd0, rst_out}, 32'h0000000F);
    check("lockloss_seq_done", {31'd0, seq_done}, 32'd0);
    check("lockloss_state", {30'd0, seq_state}, 32'd0);
    run_release("relock", D + LF + D);

    // Soft request coincident with lock loss reaching the FSM: one hold.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("coincide_state", {30'd0, seq_state}, 32'd0);
    hold = 0;
    while (seq_state === 2'd0 && hold < 100) begin
      step(1'b1, 1'b0);
      hold++;
    end
    check("coincide_hold_len", hold, D);

    // Randomized lock drops and soft requests against the model.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0);

    // Asynchronous reset mid-release (idx=2): immediate all-reset, restart.
    step(1'b1, 1'b1);
    wait_for_1100("arst");
    #3;
    async_reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_immediate", {28'd0, rst_out}, 32'h0000000F);
    check("arst_state", {30'd0, seq_state}, 32'd0);
    check("arst_done", {31'd0, seq_done}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    async_reset_n = 1'b1;
    run_release("arst_rerun", 3 + D + LF + D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_RST, default 4: number of sequenced reset outputs, legal range 2..16.
REQ-002 Parameter DELAY_CYCLES, default 16: clk cycles between consecutive releases, and minimum assert hold time, legal range 2..65535.
REQ-003 Parameter LOCK_FILTER, default 8: consecutive synchronized-locked cycles required before release starts, legal range 1..255.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 async_reset_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion synchronous to clk.
REQ-006 pll_locked  input  1  MMCM/PLL lock, asynchronous to clk.
REQ-007 soft_rst_req  input  1  synchronous single-cycle request to re-run the full sequence.
REQ-008 rst_out  output  NUM_RST  active-high resets to downstream domains; bit 0 released first.
REQ-009 seq_done  output  1  high when all rst_out bits are released.
REQ-010 seq_state  output  2  current state encoding: ASSERT=0, LOCK_WAIT=1, RELEASE=2, DONE=3.

Function
REQ-011 pll_locked SHALL pass through a 2-flop synchronizer marked ASYNC_REG, giving locked_s 2 cycles after the input changes.
REQ-012 FSM SHALL have exactly four states: ASSERT, LOCK_WAIT, RELEASE, DONE.
REQ-013 In ASSERT, all rst_out bits SHALL be 1, and a hold counter SHALL count DELAY_CYCLES cycles from state entry.
REQ-014 ASSERT -> LOCK_WAIT SHALL occur on the cycle the hold counter reaches DELAY_CYCLES, regardless of locked_s.
REQ-015 In LOCK_WAIT, a filter counter SHALL increment each cycle locked_s=1 and clear to 0 on any cycle locked_s=0.
REQ-016 LOCK_WAIT -> RELEASE SHALL occur when the filter counter reaches LOCK_FILTER.
REQ-017 In RELEASE, a delay counter SHALL count from 0 to DELAY_CYCLES-1 and then wrap to 0.
REQ-018 On each wrap, rst_out[idx] SHALL go to 0 and idx SHALL increment; the first release (bit 0) occurs DELAY_CYCLES cycles after RELEASE entry.
REQ-019 Released bits SHALL stay 0, and unreleased bits SHALL stay 1, until the sequence restarts.
REQ-020 RELEASE -> DONE SHALL occur in the same cycle that bit NUM_RST-1 is released; seq_done SHALL be registered high from that edge.
REQ-021 DONE SHALL be held indefinitely with rst_out all 0 while locked_s=1 and no soft_rst_req is seen.
REQ-022 locked_s=0 in LOCK_WAIT, RELEASE or DONE SHALL cause a transition to ASSERT at the next edge, with all rst_out=1 and seq_done=0 from that edge.
REQ-023 soft_rst_req=1 in LOCK_WAIT, RELEASE or DONE SHALL cause the same transition to ASSERT; soft_rst_req in ASSERT SHALL restart the hold counter at 0.
REQ-024 If lock loss and soft_rst_req occur in the same cycle, the result SHALL be one ASSERT entry, identical to either event alone.
REQ-025 Every entry to ASSERT SHALL clear idx, the delay counter and the filter counter.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-027 Counter widths SHALL be sized from their parameters, and no counter SHALL wrap except as specified in REQ-017.

Reset
REQ-028 While async_reset_n=0: state=ASSERT, rst_out all 1, seq_done=0, all counters 0, idx=0, synchronizer flops 0.
REQ-029 async_reset_n deassertion SHALL be internally synchronized (3-stage, async-assert/sync-deassert) before the FSM leaves its reset values.
REQ-030 async_reset_n assertion mid-sequence SHALL force rst_out all 1 within the same cycle (asynchronously).

Verification
REQ-031 Defaults, pll_locked=1 throughout, reset released at cycle 0 -> rst_out[0] falls at T0, rst_out[1..3] at T0+16, T0+32, T0+48; seq_done rises with rst_out[3].
REQ-032 pll_locked toggles 0 for one cycle every 5 cycles during LOCK_WAIT (LOCK_FILTER=8) -> FSM never enters RELEASE and rst_out stays 4'b1111.
REQ-033 pll_locked drops after rst_out[1] is released -> within 3 cycles rst_out=4'b1111, seq_done=0 and state=ASSERT; the full sequence repeats once lock returns.
REQ-034 soft_rst_req pulse in DONE -> rst_out=4'b1111 the next cycle; release order and spacing repeat exactly as in REQ-031.
REQ-035 soft_rst_req and pll_locked falling edge arriving in the same cycle -> single ASSERT entry, with hold lasting exactly 16 cycles.
REQ-036 async_reset_n pulsed low during RELEASE (idx=2) -> rst_out=4'b1111 immediately; sequence restarts from ASSERT with idx=0.
